vram_data_port: RTL and testbench

VRAM_DATA_PORT -- requirements
Module: vram_data_port

---
 rtl/vram_data_port.sv | 202 ++++++++++++++++++++
 tb/tb_vram_data_port.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_data_port.sv
// VRAM data port: two auto-stepping address ports with prefetch latches,
// accessed through a small register window and bridged to a byte-wide memory bus.

module vram_addr_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_l,
  input  logic        wr_m,
  input  logic        wr_h,
  input  logic [7:0]  wrdata,
  input  logic        step_en,
  input  logic        latch_en,
  input  logic [7:0]  rddata,
  output logic [17:0] addr,
  output logic [3:0]  incr,
  output logic        decr,
  output logic [7:0]  latch
);
  logic [17:0] step;

  // incr n selects a power-of-two stride; the 18-bit add wraps naturally
  assign step = (incr == 4'd0) ? 18'd0 : (18'd1 << (incr - 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      incr  <= '0;
      decr  <= 1'b0;
      latch <= '0;
    end else begin
      if (wr_l) addr[7:0]  <= wrdata;
      if (wr_m) addr[15:8] <= wrdata;
      if (wr_h) begin
        incr        <= wrdata[7:4];
        decr        <= wrdata[3];
        addr[17:16] <= wrdata[1:0];
      end
      if (step_en)  addr  <= decr ? addr - step : addr + step;
      if (latch_en) latch <= rddata;
    end
  end
endmodule

module vram_data_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  regs_addr,
  input  logic [7:0]  regs_wrdata,
  output logic [7:0]  regs_rddata,
  input  logic        regs_strobe,
  input  logic        regs_write,
  output logic [17:0] bus_addr,
  output logic [7:0]  bus_wrdata,
  output logic        bus_write,
  output logic        bus_strobe,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rddata,
  output logic        busy
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, WRITE, FETCH} state_t;
  typedef struct packed {
    logic [17:0] addr;
    logic [7:0]  wrdata;
    logic        write;
    logic        strobe;
  } bus_req_t;

  state_t   state, state_nxt;
  logic     port_q, port_nxt;
  logic [7:0] wdata_q, wdata_nxt;
  logic     addrsel, err, err_set;
  bus_req_t req;

  logic [NUM_PORTS-1:0][17:0] p_addr;
  logic [NUM_PORTS-1:0][3:0]  p_incr;
  logic [NUM_PORTS-1:0]       p_decr;
  logic [NUM_PORTS-1:0][7:0]  p_latch;
  logic [NUM_PORTS-1:0]       wr_l, wr_m, wr_h, step_en, latch_en;

  logic is_addr, is_data, is_ctrl, dp;
  assign is_addr = (regs_addr <= 3'd2);
  assign is_data = (regs_addr == 3'd3) || (regs_addr == 3'd4);
  assign is_ctrl = (regs_addr == 3'd5);
  assign dp      = regs_addr[2];

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      vram_addr_port u_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_l     (wr_l[p]),
        .wr_m     (wr_m[p]),
        .wr_h     (wr_h[p]),
        .wrdata   (regs_wrdata),
        .step_en  (step_en[p]),
        .latch_en (latch_en[p]),
        .rddata   (bus_rddata),
        .addr     (p_addr[p]),
        .incr     (p_incr[p]),
        .decr     (p_decr[p]),
        .latch    (p_latch[p])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      port_q  <= 1'b0;
      wdata_q <= '0;
      addrsel <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      port_q  <= port_nxt;
      wdata_q <= wdata_nxt;
      if (regs_strobe && regs_write && is_ctrl) begin
        addrsel <= regs_wrdata[0];
        if (regs_wrdata[7]) err <= 1'b0;
      end
      if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    port_nxt  = port_q;
    wdata_nxt = wdata_q;
    wr_l      = '0;
    wr_m      = '0;
    wr_h      = '0;
    step_en   = '0;
    latch_en  = '0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (regs_strobe && is_addr && regs_write) begin
          case (regs_addr)
            3'd0:    wr_l[addrsel] = 1'b1;
            3'd1:    wr_m[addrsel] = 1'b1;
            default: wr_h[addrsel] = 1'b1;
          endcase
          state_nxt = FETCH;
          port_nxt  = addrsel;
        end else if (regs_strobe && is_data && !regs_write) begin
          step_en[dp] = 1'b1;
          state_nxt   = FETCH;
          port_nxt    = dp;
        end else if (regs_strobe && is_data && regs_write) begin
          state_nxt = WRITE;
          port_nxt  = dp;
          wdata_nxt = regs_wrdata;
        end
      end
      WRITE: begin
        if (bus_ack) begin
          step_en[port_q] = 1'b1;
          state_nxt       = FETCH;
        end
      end
      FETCH: begin
        if (bus_ack) begin
          latch_en[port_q] = 1'b1;
          state_nxt        = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // address/data window is locked while a bus operation is in flight
    if (state != IDLE && regs_strobe && (is_addr || is_data)) err_set = 1'b1;
  end

  always_comb begin
    regs_rddata = '0;
    case (regs_addr)
      3'd0:    regs_rddata = p_addr[addrsel][7:0];
      3'd1:    regs_rddata = p_addr[addrsel][15:8];
      3'd2:    regs_rddata = {p_incr[addrsel], p_decr[addrsel], 1'b0, p_addr[addrsel][17:16]};
      3'd3:    regs_rddata = p_latch[0];
      3'd4:    regs_rddata = p_latch[1];
      3'd5:    regs_rddata = {err, 6'b0, addrsel};
      default: regs_rddata = '0;
    endcase
  end

  // bus outputs depend only on state, so reset drops strobe without waiting for a clock
  always_comb begin
    req        = '0;
    req.strobe = (state != IDLE);
    req.write  = (state == WRITE);
    if (req.strobe) req.addr = p_addr[port_q];
    if (req.write)  req.wrdata = wdata_q;
  end

  assign bus_addr   = req.addr;
  assign bus_wrdata = req.wrdata;
  assign bus_write  = req.write;
  assign bus_strobe = req.strobe;
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_vram_data_port.sv
// Scoreboard bench for vram_data_port: a transaction-level model predicts bus
// cycles and register read data; monitors compare them as the DUT presents them.

module tb_vram_data_port;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  regs_addr;
  logic [7:0]  regs_wrdata, regs_rddata;
  logic        regs_strobe, regs_write;
  logic [17:0] bus_addr;
  logic [7:0]  bus_wrdata;
  logic        bus_write, bus_strobe, bus_ack;
  logic [7:0]  bus_rddata;
  logic        busy;

  vram_data_port dut (
    .clk(clk), .rst_n(rst_n),
    .regs_addr(regs_addr), .regs_wrdata(regs_wrdata), .regs_rddata(regs_rddata),
    .regs_strobe(regs_strobe), .regs_write(regs_write),
    .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_write(bus_write),
    .bus_strobe(bus_strobe), .bus_ack(bus_ack), .bus_rddata(bus_rddata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [7:0] mem     [262144];
  logic [7:0] ref_mem [262144];

  // reference model state
  int         m_addr[2];
  int         m_incr[2];
  bit         m_decr[2];
  logic [7:0] m_latch[2];
  bit         m_sel, m_err;
  bit         pend;
  int         pend_p, pend_a;
  logic [7:0] pend_v;

  typedef struct { bit wr; int addr; logic [7:0] data; } bus_t;
  bus_t       bus_q[$];
  logic [7:0] rd_q[$];

  function automatic int stepped(int p);
    int s;
    s = (m_incr[p] == 0) ? 0 : (1 << (m_incr[p] - 1));
    return m_decr[p] ? (m_addr[p] - s + 262144) % 262144 : (m_addr[p] + s) % 262144;
  endfunction

  function automatic void start_fetch(int p, int a);
    bus_q.push_back('{1'b0, a, 8'h00});
    pend = 1; pend_p = p; pend_a = a; pend_v = ref_mem[a];
  endfunction

  function automatic logic [7:0] rd_val(int a);
    int p;
    p = int'(m_sel);
    case (a)
      0: return 8'(m_addr[p] % 256);
      1: return 8'((m_addr[p] / 256) % 256);
      2: return 8'(m_incr[p] * 16 + (m_decr[p] ? 8 : 0) + m_addr[p] / 65536);
      3: return m_latch[0];
      4: return m_latch[1];
      5: return 8'((m_err ? 128 : 0) + (m_sel ? 1 : 0));
      default: return 8'h00;
    endcase
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      m_addr[p] = 0; m_incr[p] = 0; m_decr[p] = 0; m_latch[p] = 8'h00;
    end
    m_sel = 0; m_err = 0; pend = 0;
    bus_q.delete(); rd_q.delete();
  endfunction

  // one register access; busy_now says the DUT is mid-operation when it lands
  task automatic acc(input bit w, input int a, input logic [7:0] d, input bit busy_now);
    int p;
    if (!w) rd_q.push_back(rd_val(a));
    if (a == 5) begin
      if (w) begin m_sel = d[0]; if (d[7]) m_err = 0; end
    end else if (a <= 4) begin
      if (busy_now) m_err = 1;
      else if (a <= 2) begin
        if (w) begin
          p = int'(m_sel);
          case (a)
            0: m_addr[p] = (m_addr[p] & 'h3FF00) | int'(d);
            1: m_addr[p] = (m_addr[p] & 'h300FF) | (int'(d) << 8);
            default: begin
              m_incr[p] = int'(d[7:4]);
              m_decr[p] = d[3];
              m_addr[p] = (m_addr[p] & 'hFFFF) | (int'(d[1:0]) << 16);
            end
          endcase
          start_fetch(p, m_addr[p]);
        end
      end else begin
        p = a - 3;
        if (w) begin
          bus_q.push_back('{1'b1, m_addr[p], d});
          ref_mem[m_addr[p]] = d;
          start_fetch(p, stepped(p));
        end else begin
          m_addr[p] = stepped(p);
          start_fetch(p, m_addr[p]);
        end
      end
    end
    regs_strobe = 1'b1; regs_write = w; regs_addr = 3'(a); regs_wrdata = d;
    @(posedge clk); #1;
    regs_strobe = 1'b0; regs_write = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 60) begin @(posedge clk); #1; n++; end
    if (busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, n);
    end
    if (pend) begin
      m_addr[pend_p] = pend_a; m_latch[pend_p] = pend_v; pend = 0;
    end
  endtask

  task automatic op(input bit w, input int a, input logic [7:0] d);
    int n;
    acc(w, a, d, 1'b0);
    wait_idle(n);
  endtask

  // bus responder with programmable latency and spurious idle acks
  int ack_delay = 0, wait_cnt = 0;
  bit long_ack = 0, zero_ack = 0;
  initial begin
    bus_ack = 1'b0; bus_rddata = 8'h00;
    forever begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (!rst_n) wait_cnt = 0;
      else if (bus_strobe) begin
        if (wait_cnt >= (long_ack ? 4 : zero_ack ? 0 : ack_delay)) begin
          bus_ack = 1'b1;
          bus_rddata = mem[bus_addr];
          if (bus_write) mem[bus_addr] = bus_wrdata;
          wait_cnt = 0;
          ack_delay = $urandom_range(0, 3);
        end else wait_cnt++;
      end else begin
        wait_cnt = 0;
        if ($urandom_range(0, 7) == 0) begin bus_ack = 1'b1; bus_rddata = 8'($urandom); end
      end
    end
  end

  // monitors
  always @(negedge clk) begin
    if (rst_n && bus_strobe && bus_ack) begin
      if (bus_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL bus_unexpected: got write=%0b addr=%0h expected no cycle", bus_write, bus_addr);
      end else begin
        bus_t e;
        e = bus_q.pop_front();
        chk("bus_write", 32'(bus_write), 32'(e.wr));
        chk("bus_addr", 32'(bus_addr), 32'(e.addr));
        if (e.wr) chk("bus_wrdata", 32'(bus_wrdata), 32'(e.data));
      end
    end
    if (rst_n && regs_strobe && !regs_write) begin
      if (rd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: got %0h expected no read", regs_rddata);
      end else chk("regs_rddata", 32'(regs_rddata), 32'(rd_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen, a, a2;
    bit w, w2, started;
    logic [7:0] d;
    rst_n = 1'b0; regs_addr = '0; regs_wrdata = '0; regs_strobe = 1'b0; regs_write = 1'b0;
    for (int i = 0; i < 262144; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobe", 32'(bus_strobe), 0);
    chk("rst_write",  32'(bus_write), 0);
    chk("rst_addr",   32'(bus_addr), 0);
    chk("rst_wrdata", 32'(bus_wrdata), 0);
    chk("rst_busy",   32'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      regs_addr = 3'(i); #1;
      chk("rst_reg", 32'(regs_rddata), 0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (bus_strobe) seen = 1; end
    chk("no_prefetch_after_reset", 32'(seen), 0);

    // ADDR programming, DATA0 read steps by 1
    mem[18'h00010] = 8'hAB; ref_mem[18'h00010] = 8'hAB;
    op(1, 0, 8'h10); op(1, 1, 8'h00); op(1, 2, 8'h10);
    op(0, 3, 8'h00); op(0, 0, 8'h00);
    // wrap at top of address space on write
    op(1, 0, 8'hFF); op(1, 1, 8'hFF); op(1, 2, 8'h13);
    op(1, 3, 8'h5A); op(0, 0, 8'h00); op(0, 1, 8'h00); op(0, 2, 8'h00);
    // decrementing stride of 16
    op(1, 0, 8'h00); op(1, 1, 8'h01); op(1, 2, 8'h58);
    op(0, 3, 8'h00); op(0, 0, 8'h00); op(0, 1, 8'h00);
    // independent ports
    op(1, 5, 8'h01); op(1, 0, 8'h00); op(1, 1, 8'h02); op(1, 2, 8'h10);
    op(0, 3, 8'h00); op(0, 4, 8'h00); op(0, 4, 8'h00); op(0, 0, 8'h00);
    op(1, 5, 8'h00); op(0, 0, 8'h00); op(0, 1, 8'h00);
    // access while fetch is stalled
    long_ack = 1;
    op(1, 5, 8'h01);
    acc(0, 4, 8'h00, 1'b0);
    acc(0, 4, 8'h00, 1'b1);
    wait_idle(n);
    long_ack = 0;
    op(0, 5, 8'h00); op(0, 0, 8'h00); op(1, 5, 8'h81); op(0, 5, 8'h00);
    // zero-wait DATA write completes in WRITE + FETCH
    zero_ack = 1;
    acc(1, 4, 8'h3C, 1'b0);
    wait_idle(n);
    chk("write_latency", 32'(n), 2);
    zero_ack = 0;
    op(0, 4, 8'h00);

    for (int it = 0; it < 200; it++) begin
      a = $urandom_range(0, 7); w = 1'($urandom_range(0, 1)); d = 8'($urandom);
      started = (w && a <= 2) || a == 3 || a == 4;
      acc(w, a, d, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        a2 = $urandom_range(0, 7); w2 = 1'($urandom_range(0, 1));
        acc(w2, a2, 8'($urandom), started);
      end
      wait_idle(n);
      if ($urandom_range(0, 4) == 0) op(0, 5, 8'h00);
    end

    // reset while a write is waiting for ack
    long_ack = 1;
    regs_strobe = 1'b1; regs_write = 1'b1; regs_addr = 3'd3; regs_wrdata = 8'hC3;
    @(posedge clk); #1;
    regs_strobe = 1'b0; regs_write = 1'b0;
    chk("strobe_in_write", 32'(bus_strobe), 1);
    #2; rst_n = 1'b0; #1;
    chk("async_rst_strobe", 32'(bus_strobe), 0);
    chk("async_rst_write", 32'(bus_write), 0);
    chk("async_rst_busy", 32'(busy), 0);
    model_reset();
    long_ack = 0;
    @(posedge clk); #1; rst_n = 1'b1;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (bus_strobe) seen = 1; end
    chk("no_req_after_rst", 32'(seen), 0);
    for (int i = 0; i < 8; i++) op(0, i, 8'h00);

    chk("queues_drained", 32'(bus_q.size() + rd_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
